// File: rtl/anneal_pkg.sv
// Shared definitions for the annealer sweep controller: state encoding,
// RAM word layout defaults and the 16-bit Galois LFSR polynomial.
package anneal_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 8;

    // Word layout: spin in the MSB, field magnitude h below it.
    localparam int SPIN_BIT_DEF = DATA_W_DEF - 1;
    localparam int H_MSB_DEF    = DATA_W_DEF - 2;
    localparam int H_LSB_DEF    = 0;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form.
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LATCH = 3'd2,
        S_WRITE = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        lfsr_step = (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that advances on en. It is kept separate so other
// stochastic blocks can reuse it.
module lfsr16
    import anneal_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = lfsr_step(q_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/anneal_sweep_ctrl.sv
// One Metropolis-style sweep over the spin RAM per start pulse. Each word
// takes READ -> LATCH -> WRITE, and accepted flips are written back in place.
module anneal_sweep_ctrl
    import anneal_pkg::*;
#(
    parameter int          ADDR_W    = ADDR_W_DEF,
    parameter int          DATA_W    = DATA_W_DEF,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        temp,
    input  logic              rand_en,
    output logic              busy,
    output logic              done,
    output logic [6:0]        flips,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_q,
    output logic [2:0]        dbg_state
);

    // Handshake: start is a one-cycle request taken only in IDLE, with no
    // queueing. busy is high from the first READ through the last WRITE.
    // done pulses for one cycle in FIN, and flips is already valid then.
    localparam int CMP_W = (DATA_W > 8) ? DATA_W : 8;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [6:0]          cnt_q, cnt_d;
    logic [6:0]          flips_q, flips_d;
    logic [7:0]          temp_q, temp_d;
    logic                rand_en_q, rand_en_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   data_q, data_d;

    logic [15:0]         lfsr_q;
    logic                lfsr_en;
    logic                unused_lfsr_hi;
    logic [CMP_W-1:0]    h_cmp;
    logic [CMP_W-1:0]    t_cmp;
    logic                accept;
    logic [6:0]          cnt_next;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (lfsr_en),
        .q   (lfsr_q)
    );

    assign unused_lfsr_hi = ^lfsr_q[15:8];

    // ram_q is only meaningful in LATCH. Its result is registered into we/data.
    assign h_cmp    = CMP_W'(ram_q[DATA_W-2:0]);
    assign t_cmp    = CMP_W'(temp_q);
    assign accept   = (h_cmp < t_cmp) | (rand_en_q & (lfsr_q[7:0] < temp_q));
    assign cnt_next = cnt_q + 7'(we_q);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        flips_d   = flips_q;
        temp_d    = temp_q;
        rand_en_d = rand_en_q;
        we_d      = 1'b0;
        data_d    = data_q;
        lfsr_en   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    temp_d    = temp;
                    rand_en_d = rand_en;
                    idx_d     = '0;
                    cnt_d     = '0;
                    state_d   = S_READ;
                end
            end
            S_READ: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                lfsr_en = 1'b1;
                we_d    = accept;
                data_d  = {~ram_q[DATA_W-1], ram_q[DATA_W-2:0]};
                state_d = S_WRITE;
            end
            S_WRITE: begin
                cnt_d = cnt_next;
                if (idx_q == {ADDR_W{1'b1}}) begin
                    // The count is loaded on entry to FIN so it is valid alongside done.
                    flips_d = cnt_next;
                    state_d = S_FIN;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_READ;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            flips_q   <= '0;
            temp_q    <= '0;
            rand_en_q <= 1'b0;
            we_q      <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            flips_q   <= flips_d;
            temp_q    <= temp_d;
            rand_en_q <= rand_en_d;
            we_q      <= we_d;
            data_q    <= data_d;
        end
    end

    assign busy      = (state_q == S_READ) || (state_q == S_LATCH) || (state_q == S_WRITE);
    assign done      = (state_q == S_FIN);
    assign flips     = flips_q;
    assign ram_addr  = idx_q;
    assign ram_we    = we_q;
    assign ram_data  = data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_anneal_sweep_ctrl.sv
// Bench for anneal_sweep_ctrl: registered-read RAM model, sweep-level
// reference model with its own LFSR, and a write scoreboard.
module tb_anneal_sweep_ctrl;
    import anneal_pkg::*;

    localparam int          ADDR_W  = 6;
    localparam int          DATA_W  = 8;
    localparam int          N_WORDS = 64;
    localparam logic [15:0] SEED    = 16'hACE1;
    localparam int          LAT     = 193;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [7:0]        temp;
    logic              rand_en;
    logic              busy;
    logic              done;
    logic [6:0]        flips;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_data;
    logic [DATA_W-1:0] ram_q;
    logic [2:0]        dbg_state;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    anneal_sweep_ctrl #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .LFSR_SEED (SEED)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .temp      (temp),
        .rand_en   (rand_en),
        .busy      (busy),
        .done      (done),
        .flips     (flips),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_data  (ram_data),
        .ram_q     (ram_q),
        .dbg_state (dbg_state)
    );

    // ---------------- single_port_ram model (registered read) ----------------
    logic [DATA_W-1:0] mem      [N_WORDS];
    logic [DATA_W-1:0] init_mem [N_WORDS];
    logic              load_req = 1'b0;

    always @(posedge clk) begin
        if (load_req) begin
            mem <= init_mem;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_data;
        end
        ram_q <= mem[ram_addr];
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0]                m_lfsr;
    logic [DATA_W-1:0]          exp_mem [N_WORDS];
    int                         exp_flips;
    logic [ADDR_W+DATA_W-1:0]   exp_q[$];

    function automatic logic [15:0] ref_lfsr_next(input logic [15:0] x);
        logic [15:0] n;
        n = x >> 1;
        if (x[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    // Predicts one sweep; only the first 'limit' words are expected to land.
    task automatic model_sweep(input logic [7:0] t, input logic re, input int limit);
        logic [6:0] h;
        logic       acc;
        exp_flips = 0;
        for (int k = 0; k < N_WORDS; k++) begin
            h   = exp_mem[k][6:0];
            acc = (int'(h) < int'(t)) || (re && (int'(m_lfsr[7:0]) < int'(t)));
            if (acc && k < limit) begin
                exp_mem[k] = {~exp_mem[k][7], h};
                exp_q.push_back({6'(k), exp_mem[k]});
                exp_flips++;
            end
            m_lfsr = ref_lfsr_next(m_lfsr);
        end
    endtask

    // Scoreboard: every RAM write must match the next predicted write.
    always @(negedge clk) begin
        if (ram_we && !rst) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_write", 32'(exp_q.size()), 32'd1);
            end else begin
                check("sb_write", 32'({ram_addr, ram_data}), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_load();
        for (int k = 0; k < N_WORDS; k++) exp_mem[k] = init_mem[k];
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_mem(input string tag);
        for (int k = 0; k < N_WORDS; k++) begin
            check(tag, 32'(mem[k]), 32'(exp_mem[k]));
        end
    endtask

    task automatic pulse_start(input logic [7:0] t, input logic re);
        @(negedge clk);
        temp    = t;
        rand_en = re;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        temp    = 8'($urandom);
        rand_en = 1'($urandom);
    endtask

    // Runs a full sweep; a second start is pulsed at cycle 'repulse' (0 = none).
    task automatic run_sweep(input string tag, input logic [7:0] t, input logic re, input int repulse);
        int cyc;
        int busy_low;
        int extra_done;
        model_sweep(t, re, N_WORDS);
        pulse_start(t, re);
        cyc = 1;
        busy_low = 0;
        check({tag, "_first_busy"}, 32'(busy), 32'd1);
        check({tag, "_first_addr"}, 32'(ram_addr), 32'd0);
        while (!done && cyc < 400) begin
            if (!busy) busy_low++;
            start = (cyc + 1 == repulse);
            if (start) temp = 8'($urandom);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_done_latency"}, 32'(cyc), 32'(LAT));
        check({tag, "_busy_in_sweep"}, 32'(busy_low), 32'd0);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_flips"}, 32'(flips), 32'(exp_flips));
        extra_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        check({tag, "_single_done"}, 32'(extra_done), 32'd0);
        check({tag, "_flips_held"}, 32'(flips), 32'(exp_flips));
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        check_mem({tag, "_mem"});
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        int done_seen;
        rst      = 1'b1;
        start    = 1'b0;
        temp     = 8'h00;
        rand_en  = 1'b0;
        m_lfsr   = SEED;
        for (int k = 0; k < N_WORDS; k++) init_mem[k] = '0;

        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(ram_we), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_we", 32'(ram_we), 32'd0);
        check("reset_addr", 32'(ram_addr), 32'd0);
        check("reset_flips", 32'(flips), 32'd0);
        check("reset_data", 32'(ram_data), 32'd0);
        check("reset_state", 32'(dbg_state), 32'(S_IDLE));

        // All words below threshold: everything flips.
        for (int k = 0; k < N_WORDS; k++) init_mem[k] = 8'h05;
        apply_load();
        run_sweep("all_flip", 8'd6, 1'b0, 0);

        // Zero temperature: nothing may be written.
        for (int k = 0; k < N_WORDS; k++) init_mem[k] = 8'($urandom);
        apply_load();
        run_sweep("temp0", 8'd0, 1'b0, 0);

        // Ramp of h values with a stray start mid-sweep.
        for (int k = 0; k < N_WORDS; k++) init_mem[k] = 8'(k);
        apply_load();
        run_sweep("ramp", 8'd10, 1'b0, 50);

        // Reset during the WRITE of word 20 aborts the sweep.
        for (int k = 0; k < N_WORDS; k++) init_mem[k] = 8'h05;
        apply_load();
        model_sweep(8'd6, 1'b0, 20);
        pulse_start(8'd6, 1'b0);
        cyc = 0;
        while (!(ram_we && ram_addr == 6'd20) && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("abort_reach_w20", 32'(ram_we && ram_addr == 6'd20), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("abort_we_drop", 32'(ram_we), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_flips", 32'(flips), 32'd0);
        check("abort_addr", 32'(ram_addr), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        m_lfsr = SEED;
        check("abort_sb_empty", 32'(exp_q.size()), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || ram_we) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        check("abort_flips_after", 32'(flips), 32'd0);
        check_mem("abort_mem");

        // Stochastic acceptance from a freshly reset LFSR.
        for (int k = 0; k < N_WORDS; k++) init_mem[k] = 8'h7F;
        apply_load();
        run_sweep("rand", 8'h40, 1'b1, 0);

        // Random words and temperatures; the LFSR carries over between sweeps.
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < N_WORDS; k++) init_mem[k] = 8'($urandom);
            apply_load();
            run_sweep("random", 8'($urandom), 1'($urandom), int'($urandom_range(2, 190)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/anneal_sweep_ctrl.md
# anneal_sweep_ctrl

Sequencer that drives the 64×8 on-chip `single_port_ram` used by the annealer. It performs one Metropolis-style sweep per `start` pulse: it reads every spin word in turn, decides whether to flip the spin from the stored local-field magnitude, the sweep temperature and an internal LFSR, and writes accepted flips back. It sits directly upstream of the RAM and owns the RAM's addr/we/data pins.

## Interface
- `ADDR_W`, default 6: RAM address width; the sweep covers 2^ADDR_W words.
- `DATA_W`, default 8: RAM word width. Bit [DATA_W-1] is the spin; bits [DATA_W-2:0] hold the field magnitude h.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value. It must be non-zero.

- `clk`, in, 1: system clock (CLOCK_50 domain).
- `rst`, in, 1: reset. **One clock; reset is asynchronous and active-high.**
- `start`, in, 1: single-cycle sweep request. Sampled only in IDLE.
- `temp`, in, 8: sweep temperature, captured on an accepted `start`.
- `rand_en`, in, 1: enables the stochastic acceptance term. Captured on an accepted `start`.
- `busy`, out, 1: a sweep is in progress.
- `done`, out, 1: one-cycle pulse at the end of a sweep.
- `flips`, out, 7: number of flips in the last completed sweep (0..64). Held until the next `start`.
- `ram_addr`, out, ADDR_W: RAM address.
- `ram_we`, out, 1: RAM write enable.
- `ram_data`, out, DATA_W: RAM write data.
- `ram_q`, in, DATA_W: RAM read data.

## Operation
- States: IDLE, READ, LATCH, WRITE, FIN.
- IDLE:
  - `start`=1 → capture `temp` and `rand_en`, set idx=0, clear the flip counter, go to READ.
  - `start`=0 → stay in IDLE.
- READ: drive `ram_addr`=idx with `ram_we`=0.
- LATCH: `ram_q` holds word[idx], because the RAM has registered read, 1-cycle latency.
  - Register the word.
  - Compute accept = ({1'b0,h} < temp_r) | (rand_en_r & (lfsr[7:0] < temp_r)).
- WRITE: `ram_we`=accept, `ram_data`={~spin, h}, `ram_addr` held at idx.
  - If accept, increment the counter.
  - If idx == 2^ADDR_W−1, go to FIN. Otherwise idx++ and go to READ.
- FIN: copy the counter to `flips`, pulse `done`, return to IDLE.
- The counter is 7 bits wide and cannot overflow, since the maximum is 64.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11+1.
  - Advances once per LATCH state only, so it is deterministic per word.
  - Resets to `LFSR_SEED`. It is never cleared by `start`.
- `start` outside IDLE is ignored, with no queueing. Changes to `temp` or `rand_en` mid-sweep have no effect.

## Timing
- Outputs during `rst` and after reset: `busy`=0, `done`=0, `flips`=0, `ram_addr`=0, `ram_we`=0, `ram_data`=0, state=IDLE.
- `ram_we` clears asynchronously with `rst`. A reset mid-sweep aborts it:
  - words already written keep their new values;
  - the remaining words are untouched;
  - `flips` reads 0;
  - no `done` is issued.
- `start` sampled at edge N → READ(addr 0) in cycle N+1.
- Each word takes exactly 3 cycles, whether or not it is accepted.
- `done`=1 in cycle N+1+3·64 = N+193 for the default parameters.
- `busy`=1 from cycle N+1 through the last WRITE, and 0 in FIN.
- The earliest next `start` is accepted in the first IDLE cycle after FIN.
- All outputs are registered or decoded from the state register. There is no combinational path from `ram_q` to any output.
- `ram_addr` is stable across READ, LATCH and WRITE of a word. `ram_data` is meaningful only while `ram_we`=1.

## Structure
- `anneal_pkg` holds:
  - the state enum;
  - `ADDR_W`/`DATA_W` defaults;
  - the spin bit index and the h field slice;
  - the LFSR tap mask and default seed.
- Sub-module `lfsr16`: inputs clk, rst, en, seed parameter; output q[15:0]. It is shared with future stochastic blocks.
- The FSM, index counter, flip counter and acceptance compare live in `anneal_sweep_ctrl`.

## Test plan
Bench uses a behavioural model of `single_port_ram` (registered read) and a reference model of `lfsr16`.
- Reset: assert `rst` for 3 cycles → `busy`=0, `done`=0, `ram_we`=0, `ram_addr`=0, `flips`=0.
- All words 8'h05, `temp`=6, `rand_en`=0 → all 64 words become 8'h85, `flips`=64, `done` exactly 193 cycles after `start`.
- `temp`=0, `rand_en`=0 → `ram_we` never asserts, RAM unchanged, `flips`=0, `done` at +193.
- word[k]=k (spin 0, h=k), `temp`=10, `rand_en`=0 → words 0..9 become 8'h80|k, words 10..63 unchanged, `flips`=10.
- `start` re-pulsed at +50 → ignored, a single `done`. A second run with `rst` asserted during WRITE of addr 20 → `ram_we` drops immediately, addr 0..19 updated, 20..63 unchanged, `flips`=0, no `done`.
- All words 8'h7F, `temp`=8'h40, `rand_en`=1 → flipped addresses and the `flips` count match the LFSR reference model word-for-word.
